// File: rtl/stream_demux_4.sv
// Four-way stream demultiplexer. Each channel has a single-entry skid-free buffer.
// A channel can be loaded and drained in the same cycle, so each channel sustains one word per cycle.
module stream_demux_4 #(
  parameter int N = 64
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_data,
  input  logic [1:0]   i_s,
  input  logic         i_valid,
  output logic         o_ready,
  output logic [N-1:0] o_data0,
  output logic [N-1:0] o_data1,
  output logic [N-1:0] o_data2,
  output logic [N-1:0] o_data3,
  output logic [3:0]   o_valid,
  input  logic [3:0]   i_ready
);

  logic [N-1:0] dreg [4];
  logic [3:0]   vreg;
  logic         load;

  // The addressed channel accepts when it is empty or is being drained this cycle.
  assign o_ready = !vreg[i_s] || i_ready[i_s];
  assign load    = i_valid && o_ready;

  // A load on a channel takes priority over its drain, which keeps the valid flag set.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < 4; k++) begin
        dreg[k] <= '0;
        vreg[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (load && (i_s == 2'(k))) begin
          dreg[k] <= i_data;
          vreg[k] <= 1'b1;
        end else if (vreg[k] && i_ready[k]) begin
          vreg[k] <= 1'b0;
        end
      end
    end
  end

  assign o_data0 = dreg[0];
  assign o_data1 = dreg[1];
  assign o_data2 = dreg[2];
  assign o_data3 = dreg[3];
  assign o_valid = vreg;

endmodule
